// File: rtl/req_gnt_responder.sv
// Responder side of the req/gnt handshake: latency-delayed registered grant,
// hold cap with timeout pulse, post-grant cooldown and saturating grant count.
module req_gnt_responder #(
  parameter int GNT_LATENCY = 2,
  parameter int MAX_HOLD    = 4,
  parameter int COOLDOWN    = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             gnt,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] gnt_count
);

  localparam int LW = $clog2(GNT_LATENCY + 1);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  generate
    if (GNT_LATENCY < 1) begin : g_bad_lat
      $error("GNT_LATENCY must be >= 1");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
      $error("MAX_HOLD must be >= 1");
    end
    if (COOLDOWN < 0) begin : g_bad_cool
      $error("COOLDOWN must be >= 0");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GRANT,
    COOL
  } state_t;

  state_t state, state_n;

  logic [LW-1:0] lat_cnt, lat_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [CW-1:0] cool_cnt, cool_n;
  logic          to_n;
  logic          enter;

  always_comb begin
    state_n = state;
    lat_n   = lat_cnt;
    hold_n  = hold_cnt;
    cool_n  = cool_cnt;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          lat_n   = LW'(1);
          hold_n  = '0;
          state_n = (GNT_LATENCY == 1) ? GRANT : WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          state_n = IDLE;
        end else if (lat_cnt == LW'(GNT_LATENCY)) begin
          state_n = GRANT;
          hold_n  = '0;
        end else begin
          lat_n = lat_cnt + LW'(1);
        end
      end
      GRANT: begin
        // Only a cap-limited exit with req still high is a timeout.
        if (!req || hold_cnt == HW'(MAX_HOLD - 1)) begin
          to_n    = req;
          cool_n  = '0;
          state_n = (COOLDOWN == 0) ? IDLE : COOL;
        end else begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      COOL: begin
        if (cool_cnt == CW'(COOLDOWN - 1)) begin
          state_n = IDLE;
        end else begin
          cool_n = cool_cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign enter = (state_n == GRANT) && (state != GRANT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      hold_cnt  <= '0;
      cool_cnt  <= '0;
      gnt       <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      gnt_count <= '0;
    end else begin
      state    <= state_n;
      lat_cnt  <= lat_n;
      hold_cnt <= hold_n;
      cool_cnt <= cool_n;
      gnt      <= (state_n == GRANT);
      busy     <= (state_n != IDLE);
      timeout  <= to_n;
      if (enter && gnt_count != {CNT_W{1'b1}}) begin
        gnt_count <= gnt_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_req_gnt_responder.sv
// Directed bench for req_gnt_responder: per-edge output log compared
// against hand-derived waveforms for each scenario.
module tb_req_gnt_responder;

  logic       clk;
  logic       rst;
  logic       req;
  logic       gnt, busy, timeout;
  logic [7:0] gnt_count;
  logic       gnt2, busy2, timeout2;
  logic [1:0] gnt_count2;

  int checks;
  int failures;
  int ecnt;

  logic [31:0] lg, lb, lt;
  logic [7:0]  lc  [0:31];
  logic [1:0]  lc2 [0:31];

  req_gnt_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .busy      (busy),
    .timeout   (timeout),
    .gnt_count (gnt_count)
  );

  req_gnt_responder #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt2),
    .busy      (busy2),
    .timeout   (timeout2),
    .gnt_count (gnt_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) ecnt = 0;
    else     ecnt = ecnt + 1;
  end

  // Outputs logged on the falling edge, indexed by the rising edge number.
  always @(negedge clk) begin
    if (rst) begin
      lg = '0;
      lb = '0;
      lt = '0;
      for (int i = 0; i < 32; i++) begin
        lc[i]  = '0;
        lc2[i] = '0;
      end
    end else if (ecnt > 0 && ecnt < 32) begin
      lg[ecnt]  = gnt;
      lb[ecnt]  = busy;
      lt[ecnt]  = timeout;
      lc[ecnt]  = gnt_count;
      lc2[ecnt] = gnt_count2;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req <= 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // req is driven nonblocking so a zero skew still lands after the edge.
  task automatic run(input logic [31:0] pat, input int sk, input int n);
    req <= pat[1];
    for (int k = 2; k <= n; k++) begin
      @(posedge clk);
      if (sk > 0) #(sk);
      req <= pat[k];
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    req <= 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req <= 1'b0;
    #1;
    checks++;
    if ({gnt, busy, timeout, gnt_count} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0",
               {gnt, busy, timeout, gnt_count});
    end
    checks++;
    if ({gnt2, busy2, timeout2, gnt_count2} !== 5'd0) begin
      failures++;
      $display("FAIL reset_outputs2 got=%b want=0",
               {gnt2, busy2, timeout2, gnt_count2});
    end
  endtask

  task automatic test_basic();
    do_reset();
    run(32'h0000_003C, 3, 10);
    checks++;
    if (lg !== 32'h30) begin
      failures++;
      $display("FAIL basic_gnt got=%h want=%h", lg, 32'h30);
    end
    checks++;
    if (lb !== 32'h7C) begin
      failures++;
      $display("FAIL basic_busy got=%h want=%h", lb, 32'h7C);
    end
    checks++;
    if (lt !== 32'h0) begin
      failures++;
      $display("FAIL basic_timeout got=%h want=0", lt);
    end
    checks++;
    if (lc[3] !== 8'd0) begin
      failures++;
      $display("FAIL basic_cnt_e3 got=%0d want=0", lc[3]);
    end
    checks++;
    if (lc[4] !== 8'd1) begin
      failures++;
      $display("FAIL basic_cnt_e4 got=%0d want=1", lc[4]);
    end
    checks++;
    if (lc[10] !== 8'd1) begin
      failures++;
      $display("FAIL basic_cnt_e10 got=%0d want=1", lc[10]);
    end
  endtask

  task automatic test_abort();
    do_reset();
    run(32'h0000_0004, 3, 6);
    checks++;
    if (lg !== 32'h0) begin
      failures++;
      $display("FAIL abort_gnt got=%h want=0", lg);
    end
    checks++;
    if (lb !== 32'h4) begin
      failures++;
      $display("FAIL abort_busy got=%h want=%h", lb, 32'h4);
    end
    checks++;
    if (lc[6] !== 8'd0 || lt !== 32'h0) begin
      failures++;
      $display("FAIL abort_cnt got=%0d/%h want=0/0", lc[6], lt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run(32'h0000_7FFC, 4, 14);
    checks++;
    if (lg !== 32'h70F0) begin
      failures++;
      $display("FAIL timeout_gnt got=%h want=%h", lg, 32'h70F0);
    end
    checks++;
    if (lb !== 32'h7DFC) begin
      failures++;
      $display("FAIL timeout_busy got=%h want=%h", lb, 32'h7DFC);
    end
    checks++;
    if (lt !== 32'h100) begin
      failures++;
      $display("FAIL timeout_pulse got=%h want=%h", lt, 32'h100);
    end
    checks++;
    if (lc[11] !== 8'd1 || lc[12] !== 8'd2) begin
      failures++;
      $display("FAIL timeout_cnt got=%0d,%0d want=1,2", lc[11], lc[12]);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    run(32'h0000_001C, 2, 4);
    checks++;
    if (gnt !== 1'b1 || gnt_count !== 8'd1) begin
      failures++;
      $display("FAIL midrst_pre got=%b/%0d want=1/1", gnt, gnt_count);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, busy, timeout, gnt_count} !== 11'd0) begin
      failures++;
      $display("FAIL midrst_async got=%b want=0",
               {gnt, busy, timeout, gnt_count});
    end
    do_reset();
    run(32'h0000_003C, 2, 10);
    checks++;
    if (lg !== 32'h30 || lc[4] !== 8'd1) begin
      failures++;
      $display("FAIL midrst_restart got=%h/%0d want=30/1", lg, lc[4]);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] pat;
    pat = '0;
    for (int k = 1; k <= 25; k++) pat[k] = ((k - 1) % 5) < 3;
    do_reset();
    run(pat, 3, 25);
    checks++;
    if (lc2[3] !== 2'd1) begin
      failures++;
      $display("FAIL sat_g1 got=%0d want=1", lc2[3]);
    end
    checks++;
    if (lc2[8] !== 2'd2) begin
      failures++;
      $display("FAIL sat_g2 got=%0d want=2", lc2[8]);
    end
    checks++;
    if (lc2[13] !== 2'd3) begin
      failures++;
      $display("FAIL sat_g3 got=%0d want=3", lc2[13]);
    end
    checks++;
    if (lc2[18] !== 2'd3) begin
      failures++;
      $display("FAIL sat_g4 got=%0d want=3", lc2[18]);
    end
    checks++;
    if (lc2[23] !== 2'd3) begin
      failures++;
      $display("FAIL sat_g5 got=%0d want=3", lc2[23]);
    end
    checks++;
    if (lc[23] !== 8'd5) begin
      failures++;
      $display("FAIL sat_wide got=%0d want=5", lc[23]);
    end
  endtask

  task automatic test_skew();
    int          sks [3];
    logic [31:0] ref_g;
    sks[0] = 0;
    sks[1] = 2;
    sks[2] = 5;
    ref_g = '0;
    for (int i = 0; i < 3; i++) begin
      do_reset();
      run(32'h0000_003C, sks[i], 10);
      checks++;
      if (lg !== 32'h30 || lb !== 32'h7C) begin
        failures++;
        $display("FAIL skew_%0d got=%h/%h want=30/7c", sks[i], lg, lb);
      end
      if (i == 0) begin
        ref_g = lg;
      end else begin
        checks++;
        if (lg !== ref_g) begin
          failures++;
          $display("FAIL skew_same_%0d got=%h want=%h", sks[i], lg, ref_g);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_abort();
    test_timeout();
    test_reset_mid_grant();
    test_saturation();
    test_skew();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
